sram_fifo_ctrl: RTL
===================

# sram_fifo_ctrl

- Show-ahead FIFO controller that owns both ports of the simple dual-port SRAM (`Dual_Port_SRAM`).
- Turns a valid/ready push stream into SRAM writes, and SRAM reads back into a valid/ready pop stream.
- Hides the SRAM's one-cycle registered read latency with an output register plus a skid register, so a continuous stream runs at one word per cycle.
- Instantiated beside `Dual_Port_SRAM`; the SRAM ports connect 1:1 to the matching `O_Wr*`/`O_Rd*`/`I_RdData` ports.

## Interface
- DATA_WIDTH, 32, word width; must match the SRAM.
- RAM_DEPTH, 64, SRAM entries; power of two, ≥ 2.
- ADDR_WIDTH (local), $clog2(RAM_DEPTH).
- CNT_WIDTH (local), $clog2(RAM_DEPTH+3).

Ports:
- I_Clk  in  1  sole clock; all state on rising edge.
- I_Reset_n  in  1  reset; asynchronous, active-low.
- I_Flush  in  1  synchronous clear; has priority over every other input.
- I_PushValid  in  1  push word offered.
- O_PushReady  out  1  push can be accepted.
- I_PushData  in  DATA_WIDTH  push word.
- O_PopValid  out  1  O_PopData holds the oldest word.
- I_PopReady  in  1  consumer takes the word.
- O_PopData  out  DATA_WIDTH  oldest word; registered.
- O_Count  out  CNT_WIDTH  total words held.
- O_WrEn, O_WrAddr, O_WrData  out  1/ADDR_WIDTH/DATA_WIDTH  SRAM write port.
- O_RdEn, O_RdAddr  out  1/ADDR_WIDTH  SRAM read port.
- I_RdData  in  DATA_WIDTH  SRAM read data; valid the cycle after O_RdEn.

## Operation
- **State:** WrPtr, RdPtr (ADDR_WIDTH, wrap naturally), RamCnt (0..RAM_DEPTH), RdPending, OutValid/OutData, SkidValid/SkidData.
- **Push:** push_fire = I_PushValid & O_PushReady.
  - O_PushReady = (RamCnt != RAM_DEPTH) & ~I_Flush.
  - O_WrEn = push_fire; O_WrAddr = WrPtr; O_WrData = I_PushData. All combinational.
  - WrPtr increments on push_fire.
- **Read issue:** occ = OutValid + SkidValid + RdPending; pop_fire = O_PopValid & I_PopReady.
  - O_RdEn = (RamCnt != 0) & ((occ − pop_fire) < 2) & ~I_Flush.
  - O_RdAddr = RdPtr; RdPtr increments on O_RdEn.
  - RdPending <= O_RdEn.
  - RamCnt uses registered values only: a word is read no earlier than the cycle after its write. The SRAM's read-during-write behaviour is therefore never relied on.
- **RamCnt:** RamCnt <= RamCnt + push_fire − O_RdEn.
- **Capture:** when RdPending, I_RdData is captured at the edge.
  - To Out if (~OutValid | pop_fire) & ~SkidValid.
  - Otherwise to Skid.
- **Pop:** on pop_fire, Skid moves to Out if SkidValid. Otherwise Out takes the captured word, or clears.
  - Order is strictly FIFO.
  - O_PopValid = OutValid.
- **O_Count:** RamCnt + OutValid + SkidValid + RdPending. Capacity is RAM_DEPTH+2.
- **Flush:** at the edge with I_Flush=1: pointers, RamCnt, RdPending, OutValid and SkidValid are cleared.
  - Push and pop during that cycle are ignored.
  - Read data returning the next cycle is discarded (RdPending is already 0).
- **Reset:** async clear of the same state.
  - While I_Reset_n=0: O_PushReady=0, O_PopValid=0, O_WrEn=0, O_RdEn=0, O_Count=0, addresses 0, O_PopData=0.
  - Reset mid-stream drops all contents, including an in-flight read.

## Timing
- **First-word latency:** push accepted in cycle 0.
  - Cycle 1: O_RdEn=1.
  - Cycle 2: I_RdData valid.
  - Cycle 3: O_PopValid=1.
- **Throughput:** 1 word/cycle each direction, sustained indefinitely with I_PopReady held at 1.
- **Full:** O_PushReady falls in the cycle after RamCnt reaches RAM_DEPTH. It rises the cycle after the next read issue.
- **Backpressure:** with I_PopReady=0, reads continue until occ=2. The last word drains from RAM into Out/Skid; no word is ever overwritten.
- **Simultaneous push and read issue at RamCnt=RAM_DEPTH:** impossible, because O_PushReady=0.
- **Simultaneous push and read issue at RamCnt=0:** no read is issued.
- **Empty:** O_PopValid=0 whenever Out is empty. O_PopData holds its last value.

## Test plan
- **Single word:** after reset push 0xA5A5_0001 in cycle 0 -> O_RdEn in cycle 1 at addr 0; O_PopValid=1 with 0xA5A5_0001 in cycle 3; O_Count 1 throughout cycles 1-3.
- **Fill:** RAM_DEPTH=64, I_PopReady=0, push 1..100 continuously.
  - 66 words accepted; O_Count=66; O_PushReady=0.
  - Then pop all -> 1..66 in order, no duplicates.
- **Streaming:** push and pop every cycle for 1000 words -> no bubble after the first 3 cycles; output sequence equals input.
- **Wrap-around:** random valid/ready (50%) for 500 words -> pointers wrap ≥7 times; scoreboard matches; O_Count never exceeds 66.
- **Flush:** I_Flush asserted in the cycle after an O_RdEn while Out and Skid are full.
  - O_Count=0 next cycle; returning I_RdData ignored.
  - Next push 0x1234 pops as 0x1234 from address 0.
- **Reset:** I_Reset_n low mid-stream with 10 words held -> all outputs at reset values immediately; after release, FIFO is empty and accepts from address 0.

Source files
------------

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: push/pop streams, flush, fill count and SRAM port bundle for sram_fifo_ctrl.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 64
);
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
  localparam int CNT_WIDTH  = $clog2(RAM_DEPTH + 3);
  logic                  I_Flush;
  logic                  I_PushValid;
  logic                  O_PushReady;
  logic [DATA_WIDTH-1:0] I_PushData;
  logic                  O_PopValid;
  logic                  I_PopReady;
  logic [DATA_WIDTH-1:0] O_PopData;
  logic [CNT_WIDTH-1:0]  O_Count;
  logic                  O_WrEn;
  logic [ADDR_WIDTH-1:0] O_WrAddr;
  logic [DATA_WIDTH-1:0] O_WrData;
  logic                  O_RdEn;
  logic [ADDR_WIDTH-1:0] O_RdAddr;
  logic [DATA_WIDTH-1:0] I_RdData;
  modport master (
    output I_Flush, I_PushValid, I_PushData, I_PopReady, I_RdData,
    input  O_PushReady, O_PopValid, O_PopData, O_Count,
           O_WrEn, O_WrAddr, O_WrData, O_RdEn, O_RdAddr
  );
  modport slave (
    input  I_Flush, I_PushValid, I_PushData, I_PopReady, I_RdData,
    output O_PushReady, O_PopValid, O_PopData, O_Count,
           O_WrEn, O_WrAddr, O_WrData, O_RdEn, O_RdAddr
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: show-ahead FIFO over a dual-port SRAM; out + skid registers hide the 1-cycle read latency.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 64
) (
  input logic             I_Clk,
  input logic             I_Reset_n,
  sram_fifo_ctrl_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
  localparam int CNT_WIDTH  = $clog2(RAM_DEPTH + 3);
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_pend, r_out_valid, r_skid_valid;
  logic [DATA_WIDTH-1:0] r_out_data, r_skid_data;
  logic                  w_push_ready, w_push_fire, w_pop_fire, w_rd_en, w_out_free;
  logic [1:0]            w_occ;
  // Ready is gated by reset so nothing is accepted while the FIFO is held cleared.
  assign w_push_ready = I_Reset_n & (r_ram_cnt != (ADDR_WIDTH+1)'(RAM_DEPTH)) & ~bus.I_Flush;
  assign w_push_fire  = bus.I_PushValid & w_push_ready;
  assign w_pop_fire   = r_out_valid & bus.I_PopReady;
  assign w_occ        = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_rd_pend};
  assign w_rd_en      = (r_ram_cnt != '0) & ((w_occ - {1'b0, w_pop_fire}) < 2'd2) & ~bus.I_Flush;
  assign w_out_free   = ~r_out_valid | w_pop_fire;
  assign bus.O_PushReady = w_push_ready;
  assign bus.O_WrEn      = w_push_fire;
  assign bus.O_WrAddr    = r_wr_ptr;
  assign bus.O_WrData    = bus.I_PushData;
  assign bus.O_RdEn      = w_rd_en;
  assign bus.O_RdAddr    = r_rd_ptr;
  assign bus.O_PopValid  = r_out_valid;
  assign bus.O_PopData   = r_out_data;
  assign bus.O_Count     = CNT_WIDTH'(r_ram_cnt) + CNT_WIDTH'(r_out_valid)
                         + CNT_WIDTH'(r_skid_valid) + CNT_WIDTH'(r_rd_pend);
  always_ff @(posedge I_Clk or negedge I_Reset_n) begin
    if (!I_Reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_cnt    <= '0;
      r_rd_pend    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (bus.I_Flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_cnt    <= '0;
      r_rd_pend    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt <= r_ram_cnt + (ADDR_WIDTH+1)'(w_push_fire) - (ADDR_WIDTH+1)'(w_rd_en);
      r_rd_pend <= w_rd_en;
      // Skid always holds the older word, so it refills Out before fresh read data does.
      if (w_out_free) begin
        r_out_valid  <= r_skid_valid | r_rd_pend;
        r_skid_valid <= r_skid_valid & r_rd_pend;
        if (r_skid_valid) r_out_data <= r_skid_data;
        else if (r_rd_pend) r_out_data <= bus.I_RdData;
        if (r_skid_valid & r_rd_pend) r_skid_data <= bus.I_RdData;
      end else if (r_rd_pend) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= bus.I_RdData;
      end
    end
  end
endmodule
